// File: rtl/aui_lanes_pkg.sv
// aui_lanes_pkg: shared defaults, lane slot type and reference beat mapping for the AUI lane distributor
package aui_lanes_pkg;
    localparam int DEF_SYM_W      = 10;
    localparam int DEF_SYM_PER_CW = 544;
    localparam int DEF_N_CW       = 4;
    localparam int DEF_N_LANES    = 16;
    localparam int DEF_AM_PERIOD  = 8192;
    localparam int DEF_CW_W       = DEF_SYM_PER_CW * DEF_SYM_W;
    localparam int DEF_LANE_W     = (DEF_SYM_PER_CW / DEF_N_LANES) * DEF_N_CW * DEF_SYM_W;

    typedef logic [DEF_SYM_W-1:0] lane_slot_t;

    // Default-geometry mapping: symbol s of codeword c lands on lane s%N_LANES,
    // slot s/N_LANES, interleaved with the other codewords inside the slot.
    function automatic logic [DEF_N_LANES*DEF_LANE_W-1:0] map_beat(
        input logic [DEF_N_CW*DEF_CW_W-1:0] cw
    );
        logic [DEF_N_LANES*DEF_LANE_W-1:0] r;
        lane_slot_t sym;
        r = '0;
        for (int c = 0; c < DEF_N_CW; c++) begin
            for (int s = 0; s < DEF_SYM_PER_CW; s++) begin
                sym = cw[c*DEF_CW_W + DEF_CW_W-1 - s*DEF_SYM_W -: DEF_SYM_W];
                r[(s % DEF_N_LANES)*DEF_LANE_W + (DEF_N_CW*(s / DEF_N_LANES) + c)*DEF_SYM_W +: DEF_SYM_W] = sym;
            end
        end
        return r;
    endfunction
endpackage

// File: rtl/aui_skid_buf.sv
// aui_skid_buf: generic 2-entry valid/ready buffer with registered o_ready
//   clk, rst         clock, synchronous active-high reset
//   i_valid/o_ready  upstream handshake, i_data payload in
//   o_valid/i_ready  downstream handshake, o_data payload out (held while stalled)
module aui_skid_buf #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);
    logic         r_main_v, r_skid_v, r_ready;
    logic [W-1:0] r_main, r_skid;
    logic         w_acc, w_drain, w_main_free, w_skid_v_nxt;

    assign w_acc        = i_valid && r_ready;
    assign w_drain      = r_main_v && i_ready;
    assign w_main_free  = !r_main_v || w_drain;
    // o_ready can only be high while the skid is empty, so a full skid never sees an accept
    assign w_skid_v_nxt = r_skid_v ? !w_drain : (w_acc && !w_main_free);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_ready  <= 1'b0;
            r_main   <= '0;
        end else begin
            r_skid_v <= w_skid_v_nxt;
            r_ready  <= !w_skid_v_nxt;
            if (w_main_free) begin
                r_main_v <= r_skid_v || w_acc;
                if (r_skid_v)
                    r_main <= r_skid;
                else if (w_acc)
                    r_main <= i_data;
            end
        end
    end

    always_ff @(posedge clk)
        if (w_acc && !w_main_free)
            r_skid <= i_data;

    assign o_ready = r_ready;
    assign o_valid = r_main_v;
    assign o_data  = r_main;
endmodule

// File: rtl/aui_lane_dist.sv
// aui_lane_dist: RS-FEC symbol distributor, N_CW codewords per beat round-robined onto N_LANES lanes
//   clk, rst          clock, synchronous active-high reset
//   i_valid/o_ready   input beat handshake (o_ready registered)
//   i_cw              codeword c at [c*CW_W +: CW_W], symbol 0 in the MSBs
//   o_valid/i_ready   output beat handshake
//   o_lanes           lane l at [l*LANE_W +: LANE_W]
//   o_sync            beat is the first of an AM period
//   i_lane_swap       reverse lane order, present only with `define AUI_LANE_SWAP_EN
module aui_lane_dist
    import aui_lanes_pkg::*;
#(
    parameter int SYM_W      = DEF_SYM_W,
    parameter int SYM_PER_CW = DEF_SYM_PER_CW,
    parameter int N_CW       = DEF_N_CW,
    parameter int N_LANES    = DEF_N_LANES,
    parameter int AM_PERIOD  = DEF_AM_PERIOD,
    localparam int CW_W      = SYM_PER_CW * SYM_W,
    localparam int LANE_W    = (SYM_PER_CW / N_LANES) * N_CW * SYM_W
) (
    input  logic                      clk,
    input  logic                      rst,
`ifdef AUI_LANE_SWAP_EN
    input  logic                      i_lane_swap,
`endif
    input  logic                      i_valid,
    output logic                      o_ready,
    input  logic [N_CW*CW_W-1:0]      i_cw,
    output logic                      o_valid,
    input  logic                      i_ready,
    output logic [N_LANES*LANE_W-1:0] o_lanes,
    output logic                      o_sync
);
    localparam int BEAT_W = N_LANES * LANE_W;
    localparam int CNT_W  = $clog2(AM_PERIOD);

    if (SYM_PER_CW % N_LANES != 0) begin : g_bad_div
        $fatal(1, "aui_lane_dist: SYM_PER_CW must be divisible by N_LANES");
    end
    if (AM_PERIOD < 2) begin : g_bad_am
        $fatal(1, "aui_lane_dist: AM_PERIOD must be at least 2");
    end

    logic [BEAT_W-1:0] w_lanes, w_lanes_out;
    logic              w_acc, w_sync;
    logic [CNT_W-1:0]  r_cnt;

    genvar c, s, l;
    for (c = 0; c < N_CW; c++) begin : g_cw
        for (s = 0; s < SYM_PER_CW; s++) begin : g_sym
            assign w_lanes[(s % N_LANES)*LANE_W + (N_CW*(s / N_LANES) + c)*SYM_W +: SYM_W] =
                i_cw[c*CW_W + CW_W-1 - s*SYM_W -: SYM_W];
        end
    end

`ifdef AUI_LANE_SWAP_EN
    // Swap is applied before capture so it travels with its beat through the buffer
    for (l = 0; l < N_LANES; l++) begin : g_swap
        assign w_lanes_out[l*LANE_W +: LANE_W] = i_lane_swap ? w_lanes[(N_LANES-1-l)*LANE_W +: LANE_W]
                                                             : w_lanes[l*LANE_W +: LANE_W];
    end
`else
    assign w_lanes_out = w_lanes;
`endif

    assign w_acc  = i_valid && o_ready;
    assign w_sync = r_cnt == '0;

    always_ff @(posedge clk) begin
        if (rst)
            r_cnt <= '0;
        else if (w_acc)
            r_cnt <= (r_cnt == CNT_W'(AM_PERIOD-1)) ? '0 : r_cnt + 1'b1;
    end

    aui_skid_buf #(.W(BEAT_W + 1)) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  ({w_sync, w_lanes_out}),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  ({o_sync, o_lanes})
    );
endmodule

// File: tb/tb_aui_lane_dist.sv
// tb_aui_lane_dist: scoreboard bench for aui_lane_dist mapping, AM sync, skid flow control and reset
module tb_aui_lane_dist;
    localparam int SYM_W = 10, SYM_PER_CW = 544, N_CW = 4, N_LANES = 16, AM = 8192;
    localparam int CW_W = SYM_PER_CW * SYM_W;
    localparam int LANE_W = (SYM_PER_CW / N_LANES) * N_CW * SYM_W;
    localparam int CWS = N_CW * CW_W;
    localparam int BW = N_LANES * LANE_W;

    logic clk = 0, rst = 1, i_valid = 0, i_ready = 1;
    logic o_ready, o_valid, o_sync;
    logic [CWS-1:0] i_cw = '0;
    logic [BW-1:0] o_lanes;
`ifdef AUI_LANE_SWAP_EN
    logic i_lane_swap = 0;
`endif

    int checks = 0, failures = 0, tb_cnt = 0, beat_no = 0;
    logic [BW:0] sb[$];

    always #5 clk = ~clk;

    aui_lane_dist #(.SYM_W(SYM_W), .SYM_PER_CW(SYM_PER_CW), .N_CW(N_CW), .N_LANES(N_LANES), .AM_PERIOD(AM)) dut (
        .clk(clk),
        .rst(rst),
`ifdef AUI_LANE_SWAP_EN
        .i_lane_swap(i_lane_swap),
`endif
        .i_valid(i_valid),
        .o_ready(o_ready),
        .i_cw(i_cw),
        .o_valid(o_valid),
        .i_ready(i_ready),
        .o_lanes(o_lanes),
        .o_sync(o_sync)
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
        end
    endtask

    // Walk the output side lane by lane and slot by slot, pulling the symbol each slot should hold
    function automatic logic [BW-1:0] model(input logic [CWS-1:0] cw, input bit sw);
        logic [BW-1:0] r;
        int s, ol;
        r = '0;
        for (int l = 0; l < N_LANES; l++)
            for (int k = 0; k < SYM_PER_CW / N_LANES; k++)
                for (int c = 0; c < N_CW; c++) begin
                    s  = k * N_LANES + l;
                    ol = sw ? N_LANES - 1 - l : l;
                    r[ol*LANE_W + (N_CW*k + c)*SYM_W +: SYM_W] = cw[c*CW_W + CW_W-1 - s*SYM_W -: SYM_W];
                end
        return r;
    endfunction

    function automatic logic [CWS-1:0] rand_cw();
        logic [CWS-1:0] r;
        for (int i = 0; i < CWS / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic void push(input logic [CWS-1:0] cw, input bit sw);
        sb.push_back({tb_cnt == 0, model(cw, sw)});
        tb_cnt = (tb_cnt == AM - 1) ? 0 : tb_cnt + 1;
    endfunction

    always @(negedge clk) begin
        if (!rst && o_valid && i_ready) begin
            logic [BW:0] e;
            beat_no++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_beat beat=%0d act=valid exp=none", beat_no);
            end else begin
                e = sb.pop_front();
                if (o_sync !== e[BW]) begin
                    failures++;
                    $display("FAIL sync beat=%0d act=%0b exp=%0b", beat_no, o_sync, e[BW]);
                end
                checks++;
                if (o_lanes !== e[BW-1:0]) begin
                    failures++;
                    for (int i = 0; i < BW / SYM_W; i++)
                        if (o_lanes[i*SYM_W +: SYM_W] !== e[i*SYM_W +: SYM_W]) begin
                            $display("FAIL lanes beat=%0d sym_idx=%0d act=%h exp=%h", beat_no, i,
                                     o_lanes[i*SYM_W +: SYM_W], e[i*SYM_W +: SYM_W]);
                            break;
                        end
                end
            end
        end
    end

    task automatic send(input logic [CWS-1:0] cw, input bit sw);
        bit ok = 0;
        i_valid = 1;
        i_cw = cw;
`ifdef AUI_LANE_SWAP_EN
        i_lane_swap = sw;
`endif
        for (int n = 0; n < 64 && !ok; n++) begin
            @(negedge clk);
            if (o_ready) begin
                push(cw, sw);
                ok = 1;
            end
            @(posedge clk);
            #1;
        end
        i_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        for (int n = 0; n < 200 && sb.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        chk("drain_empty", sb.size(), 0);
    endtask

    task automatic do_reset();
        rst = 1;
        @(posedge clk);
        #1;
        rst = 0;
        sb.delete();
        tb_cnt = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic rnd_run(input int n);
        int sent = 0;
        bit acc;
        logic [CWS-1:0] cw;
        while (sent < n) begin
            i_ready = 1'($urandom_range(0, 1));
            if (!i_valid) begin
                i_valid = 1'($urandom_range(0, 1));
                if (i_valid) begin
                    cw = rand_cw();
                    i_cw = cw;
                end
            end
            acc = 0;
            @(negedge clk);
            if (i_valid && o_ready) begin
                push(cw, 0);
                sent++;
                acc = 1;
            end
            @(posedge clk);
            #1;
            if (acc) i_valid = 0;
        end
        i_ready = 1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [CWS-1:0] cw;
        logic [1:0] cc;
        logic [7:0] ss;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_ready", o_ready, 0);
        chk("rst_o_sync", o_sync, 0);
        chk("rst_o_lanes_zero", o_lanes == '0, 1);
        rst = 0;
        @(posedge clk);
        #1;
        chk("post_rst_o_ready", o_ready, 1);

        // Test 1: tagged symbols {cw, s[7:0]}
        for (int c = 0; c < N_CW; c++)
            for (int s = 0; s < SYM_PER_CW; s++) begin
                cc = 2'(c);
                ss = 8'(s);
                cw[c*CW_W + CW_W-1 - s*SYM_W -: SYM_W] = {cc, ss};
            end
        chk("t1_idle_valid", o_valid, 0);
        send(cw, 0);
        chk("t1_latency_valid", o_valid, 1);
        chk("t1_sync", o_sync, 1);
        chk("t1_l0_s0_cw0", o_lanes[9:0], 10'h000);
        chk("t1_l0_s0_cw1", o_lanes[19:10], 10'h100);
        chk("t1_l1_s0_cw0", o_lanes[LANE_W +: 10], 10'h001);
        chk("t1_l15_top", o_lanes[15*LANE_W + 1350 +: 10], 10'h31F);
        drain();

        // Test 2: AM_PERIOD+1 back-to-back beats, sync on first and last only
        do_reset();
        cw = rand_cw();
        for (int b = 0; b < AM + 1; b++) begin
            cw[31:0] = 32'(b);
            send({CWS / 32{cw[31:0] ^ 32'h9E3779B9}}, 0);
        end
        drain();

        // Test 3: stall with i_valid high, two beats absorbed then o_ready drops
        do_reset();
        i_ready = 0;
        send(rand_cw(), 0);
        send(rand_cw(), 0);
        i_valid = 1;
        @(negedge clk);
        chk("t3_stall_ready", o_ready, 0);
        chk("t3_stall_valid", o_valid, 1);
        chk("t3_stall_sync", o_sync, 1);
        @(posedge clk);
        #1;
        i_ready = 1;
        send(rand_cw(), 0);
        drain();

        // Test 4: random valid/ready
        do_reset();
        rnd_run(3000);
        drain();

        // Test 5: reset with skid full discards both beats
        do_reset();
        i_ready = 0;
        send(rand_cw(), 0);
        send(rand_cw(), 0);
        rst = 1;
        @(posedge clk);
        #1;
        chk("t5_rst_valid", o_valid, 0);
        chk("t5_rst_ready", o_ready, 0);
        rst = 0;
        sb.delete();
        tb_cnt = 0;
        @(posedge clk);
        #1;
        chk("t5_post_ready", o_ready, 1);
        chk("t5_post_valid", o_valid, 0);
        i_ready = 1;
        send(rand_cw(), 0);
        chk("t5_first_sync", o_sync, 1);
        drain();

`ifdef AUI_LANE_SWAP_EN
        // Test 6: lane reversal on the middle beat only
        do_reset();
        send(rand_cw(), 0);
        cw = rand_cw();
        send(cw, 1);
        chk("t6_l0_is_l15", o_lanes[63:0], model(cw, 0)[15*LANE_W +: 64]);
        send(rand_cw(), 0);
        drain();
`endif

        repeat (5) @(posedge clk);
        #1;
        chk("final_sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
